pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline control unit: merges N_REQ stall requests into a per-stage stall vector and sequences exception flushes. A flush is deferred while any full-pipeline stall (cache miss) is active. Also provides a stall watchdog and per-source stall-cycle counters. Sits beside the PC/IF/ID/EX/MEM/WB pipeline and drives every stage's hold and flush inputs.

Parameters:
N_STAGES, 6, number of pipeline stages; stall bit 0 = PC, bit N_STAGES-1 = WB
N_REQ, 5, number of stall-request sources
DEPTH_W, 3, bits per entry of REQ_DEPTH
REQ_DEPTH, {3'd6,3'd6,3'd4,3'd3,3'd3}, packed per-source stall depth; entry i = number of stages stalled from bit 0 upward (range 0..N_STAGES)
ADDR_W, 32, flush target width
MAX_STALL, 1024, consecutive-stall cycles before timeout
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset
stall_req  in  N_REQ  per-source stall request, active-high
excp_valid  in  1  exception/eret commit request, single-cycle
excp_target  in  ADDR_W  redirect address, valid with excp_valid
perf_sel  in  clog2(N_REQ)  counter readout select
perf_clr  in  1  clear all counters
stall  out  N_STAGES  per-stage hold
flush  out  1  squash all stages, one-cycle pulse
new_pc  out  ADDR_W  redirect address, valid while flush=1
busy_flush  out  1  flush pending or in progress
stall_timeout  out  1  sticky watchdog flag
perf_cnt  out  CNT_W  stall-cycle count of source perf_sel

Behaviour:
- Reset: rst is synchronous, active-high. Clocked rst=1 gives state RUN, flush=0, new_pc=0, busy_flush=0, stall_timeout=0, watchdog=0, all counters=0. stall is 0 whenever rst=1; rst has combinational priority.
- Mask: mask_i = thermometer of REQ_DEPTH[i] (depth 4 -> 6'b001111). If REQ_DEPTH[i] > N_STAGES, clamp to N_STAGES.
- raw_stall = OR of mask_i over active stall_req[i]. Because masks are thermometers, this equals the deepest active request.
- full_stall = raw_stall == all-ones.
- stall output is combinational in the same cycle: raw_stall, forced to 0 while flush=1.
- FSM states RUN, PEND, FLUSH:
  - RUN, excp_valid=1, full_stall=0: latch target; go to FLUSH next cycle.
  - RUN, excp_valid=1, full_stall=1: latch target; go to PEND.
  - PEND: hold while full_stall=1. On the first cycle full_stall=0, go to FLUSH next cycle.
  - FLUSH: flush=1 and new_pc=latched target for exactly 1 cycle, then return to RUN.
  - excp_valid in PEND or FLUSH is ignored; the first exception wins.
- Latency: exception at cycle t with no full stall gives flush=1 at t+1.
- busy_flush = state != RUN (registered state).
- new_pc holds its last value outside FLUSH.
- Watchdog: counts consecutive cycles with raw_stall != 0 and clears on any cycle with raw_stall == 0. When it reaches MAX_STALL, stall_timeout sets and stays set until rst; the counter saturates.
- Counters: cnt[i] increments each cycle stall_req[i]=1, saturating at all-ones.
  - perf_clr clears all counters and wins over increment in the same cycle.
  - perf_cnt = cnt[perf_sel], combinational. perf_sel >= N_REQ reads 0.
- Reset mid-PEND or mid-FLUSH drops the pending flush; no flush pulse after reset.

Decomposition:
- Shared package pipe_pkg: state encoding (RUN/PEND/FLUSH), default REQ_DEPTH constant, stage index constants (STG_PC..STG_WB).
- One natural sub-module: sat_counter (WIDTH, synchronous clr, inc, saturating). Instantiated N_REQ times for the counters and once for the watchdog.

Test Plan:
- Priority merge: stall_req=5'b00110 (depths 4 and 3) -> stall=6'b001111. Then 5'b10000 -> 6'b111111. Then 0 -> 6'b000000, same cycle.
- Immediate flush: excp_valid=1, excp_target=0xBFC00380, no stalls, at cycle t -> flush=1 and new_pc=0xBFC00380 at t+1 only; stall=0 during t+1; busy_flush=1 at t+1.
- Deferred flush: stall_req[4]=1 for cycles t..t+4 and excp at t -> busy_flush=1 from t+1 and no flush through t+5; flush=1 at t+6. A second excp at t+2 with target 0x80000000 is ignored; new_pc=first target.
- Watchdog: MAX_STALL=8, stall_req[1]=1 for 7 cycles, drop for 1, then 8 cycles -> stall_timeout=0 after the first burst, 1 after the 8th cycle of the second burst; stays 1 with requests idle until rst.
- Counters: stall_req[2] high 10 cycles, perf_sel=2 -> perf_cnt=10. perf_clr together with stall_req[2]=1 -> next cycle perf_cnt=0. perf_sel=7 -> 0.
- Reset mid-PEND: full stall plus excp, then rst=1 for one cycle while pending -> no flush pulse ever, busy_flush=0, all counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control unit: FSM states, stage indices
// and the default per-source stall depths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PEND,
        ST_FLUSH
    } state_e;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Entry 0 sits in the low bits: sources 0,1 -> 3, 2 -> 4, 3,4 -> 6 (full pipe).
    localparam logic [14:0] REQ_DEPTH_DEFAULT = {3'd6, 3'd6, 3'd4, 3'd3, 3'd3};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall requests into a per-stage hold vector,
// sequences exception flushes, and tracks stall watchdog and per-source counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int                          N_STAGES  = 6,
    parameter int                          N_REQ     = 5,
    parameter int                          DEPTH_W   = 3,
    parameter logic [N_REQ*DEPTH_W-1:0]    REQ_DEPTH = REQ_DEPTH_DEFAULT,
    parameter int                          ADDR_W    = 32,
    parameter int                          MAX_STALL = 1024,
    parameter int                          CNT_W     = 32,
    parameter int                          SEL_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    stall_req,
    input  logic                excp_valid,
    input  logic [ADDR_W-1:0]   excp_target,
    input  logic [SEL_W-1:0]    perf_sel,
    input  logic                perf_clr,
    output logic [N_STAGES-1:0] stall,
    output logic                flush,
    output logic [ADDR_W-1:0]   new_pc,
    output logic                busy_flush,
    output logic                stall_timeout,
    output logic [CNT_W-1:0]    perf_cnt
);

    localparam int WD_W = $clog2(MAX_STALL + 1);

    // Depths beyond the pipeline length clamp naturally: only N_STAGES bits exist.
    function automatic logic [N_STAGES-1:0] thermo(input int depth);
        logic [N_STAGES-1:0] m;
        m = '0;
        for (int s = 0; s < N_STAGES; s++) begin
            m[s] = (s < depth);
        end
        return m;
    endfunction

    logic [N_STAGES-1:0] mask [N_REQ];
    logic [N_STAGES-1:0] raw_stall;
    logic                full_stall;
    logic                stall_any;

    for (genvar g = 0; g < N_REQ; g++) begin : g_mask
        assign mask[g] = thermo(int'(REQ_DEPTH[g*DEPTH_W +: DEPTH_W]));
    end

    always_comb begin
        raw_stall = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (stall_req[i]) begin
                raw_stall = raw_stall | mask[i];
            end
        end
    end

    assign full_stall = (raw_stall == '1);
    assign stall_any  = |raw_stall;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [ADDR_W-1:0]   new_pc_q, new_pc_d;

    // First exception wins; PEND waits out the cache-miss stall before flushing.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        new_pc_d = new_pc_q;
        case (state_q)
            ST_RUN: begin
                if (excp_valid) begin
                    target_d = excp_target;
                    if (full_stall) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d  = ST_FLUSH;
                        new_pc_d = excp_target;
                    end
                end
            end
            ST_PEND: begin
                if (!full_stall) begin
                    state_d  = ST_FLUSH;
                    new_pc_d = target_q;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            target_q <= '0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign flush      = (state_q == ST_FLUSH) && !rst;
    assign stall      = (rst || flush) ? '0 : raw_stall;
    assign new_pc     = new_pc_q;
    assign busy_flush = (state_q != ST_RUN);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q, timeout_d;

    sat_counter #(.WIDTH(WD_W)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (!stall_any),
        .inc_i   (stall_any),
        .count_o (wd_cnt)
    );

    // Flag rises on the edge where the consecutive-stall count reaches MAX_STALL.
    assign timeout_d = timeout_q || (stall_any && (wd_cnt >= WD_W'(MAX_STALL - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

    logic [CNT_W-1:0] cnt [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        sat_counter #(.WIDTH(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (perf_clr),
            .inc_i   (stall_req[g]),
            .count_o (cnt[g])
        );
    end

    always_comb begin
        perf_cnt = '0;
        if (int'(perf_sel) < N_REQ) begin
            perf_cnt = cnt[perf_sel];
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; watchdog limit shortened to 8 cycles.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  stall_req;
    logic        excp_valid;
    logic [31:0] excp_target;
    logic [2:0]  perf_sel;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy_flush;
    logic        stall_timeout;
    logic [31:0] perf_cnt;

    int nVectors;
    int nMiscompares;

    pipe_ctrl #(.MAX_STALL(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .excp_valid    (excp_valid),
        .excp_target   (excp_target),
        .perf_sel      (perf_sel),
        .perf_clr      (perf_clr),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .busy_flush    (busy_flush),
        .stall_timeout (stall_timeout),
        .perf_cnt      (perf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_req = 5'b11111;
        perf_sel = 3'd4;
        tick();
        tick();
        #1;
        nVectors++;
        if (stall !== 6'b000000) begin
            nMiscompares++;
            $display("[TB] FAIL reset_stall got %b want %b", stall, 6'b000000);
        end
        nVectors++;
        if (flush !== 1'b0 || busy_flush !== 1'b0 || stall_timeout !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_flags got flush=%b busy=%b to=%b want 0 0 0", flush, busy_flush, stall_timeout);
        end
        nVectors++;
        if (new_pc !== 32'h0 || perf_cnt !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_regs got new_pc=%h cnt=%0d want 0 0", new_pc, perf_cnt);
        end
        rst = 1'b0;
        stall_req = 5'b00000;
    endtask

    task automatic test_merge();
        stall_req = 5'b00110;
        #1;
        nVectors++;
        if (stall !== 6'b001111) begin
            nMiscompares++;
            $display("[TB] FAIL merge_d4_d3 got %b want %b", stall, 6'b001111);
        end
        stall_req = 5'b10000;
        #1;
        nVectors++;
        if (stall !== 6'b111111) begin
            nMiscompares++;
            $display("[TB] FAIL merge_full got %b want %b", stall, 6'b111111);
        end
        stall_req = 5'b00001;
        #1;
        nVectors++;
        if (stall !== 6'b000111) begin
            nMiscompares++;
            $display("[TB] FAIL merge_d3 got %b want %b", stall, 6'b000111);
        end
        stall_req = 5'b00000;
        #1;
        nVectors++;
        if (stall !== 6'b000000) begin
            nMiscompares++;
            $display("[TB] FAIL merge_none got %b want %b", stall, 6'b000000);
        end
    endtask

    task automatic test_immediate_flush();
        excp_valid = 1'b1;
        excp_target = 32'hBFC00380;
        #1;
        nVectors++;
        if (flush !== 1'b0 || busy_flush !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL imm_t got flush=%b busy=%b want 0 0", flush, busy_flush);
        end
        tick();
        excp_valid = 1'b0;
        stall_req = 5'b00100;
        #1;
        nVectors++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC00380) begin
            nMiscompares++;
            $display("[TB] FAIL imm_t1 got flush=%b pc=%h want 1 bfc00380", flush, new_pc);
        end
        nVectors++;
        if (stall !== 6'b000000 || busy_flush !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL imm_t1_stall got stall=%b busy=%b want 000000 1", stall, busy_flush);
        end
        tick();
        stall_req = 5'b00000;
        #1;
        nVectors++;
        if (flush !== 1'b0 || busy_flush !== 1'b0 || new_pc !== 32'hBFC00380) begin
            nMiscompares++;
            $display("[TB] FAIL imm_t2 got flush=%b busy=%b pc=%h want 0 0 bfc00380", flush, busy_flush, new_pc);
        end
    endtask

    task automatic test_deferred_flush();
        stall_req = 5'b10000;
        excp_valid = 1'b1;
        excp_target = 32'h12345678;
        #1;
        nVectors++;
        if (stall !== 6'b111111 || busy_flush !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL def_t got stall=%b busy=%b want 111111 0", stall, busy_flush);
        end
        for (int c = 1; c <= 7; c++) begin
            tick();
            excp_valid = (c == 2);
            excp_target = (c == 2) ? 32'h80000000 : 32'h0;
            if (c == 5) stall_req = 5'b00000;
            #1;
            nVectors++;
            if (c <= 5 && (flush !== 1'b0 || busy_flush !== 1'b1)) begin
                nMiscompares++;
                $display("[TB] FAIL def_wait t+%0d got flush=%b busy=%b want 0 1", c, flush, busy_flush);
            end else if (c == 6 && (flush !== 1'b1 || new_pc !== 32'h12345678)) begin
                nMiscompares++;
                $display("[TB] FAIL def_flush got flush=%b pc=%h want 1 12345678", flush, new_pc);
            end else if (c == 7 && (flush !== 1'b0 || busy_flush !== 1'b0)) begin
                nMiscompares++;
                $display("[TB] FAIL def_done got flush=%b busy=%b want 0 0", flush, busy_flush);
            end
        end
        excp_valid = 1'b0;
    endtask

    task automatic test_watchdog();
        stall_req = 5'b00010;
        for (int c = 0; c < 7; c++) tick();
        nVectors++;
        if (stall_timeout !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL wd_burst1 got %b want 0", stall_timeout);
        end
        stall_req = 5'b00000;
        tick();
        stall_req = 5'b00010;
        for (int c = 0; c < 7; c++) tick();
        nVectors++;
        if (stall_timeout !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL wd_burst2_7 got %b want 0", stall_timeout);
        end
        tick();
        nVectors++;
        if (stall_timeout !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL wd_burst2_8 got %b want 1", stall_timeout);
        end
        stall_req = 5'b00000;
        for (int c = 0; c < 3; c++) tick();
        nVectors++;
        if (stall_timeout !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL wd_sticky got %b want 1", stall_timeout);
        end
    endtask

    task automatic test_counters();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        stall_req = 5'b00100;
        for (int c = 0; c < 10; c++) tick();
        stall_req = 5'b00000;
        perf_sel = 3'd2;
        #1;
        nVectors++;
        if (perf_cnt !== 32'd10) begin
            nMiscompares++;
            $display("[TB] FAIL cnt_src2 got %0d want 10", perf_cnt);
        end
        perf_sel = 3'd3;
        #1;
        nVectors++;
        if (perf_cnt !== 32'd0) begin
            nMiscompares++;
            $display("[TB] FAIL cnt_src3 got %0d want 0", perf_cnt);
        end
        perf_sel = 3'd7;
        #1;
        nVectors++;
        if (perf_cnt !== 32'd0) begin
            nMiscompares++;
            $display("[TB] FAIL cnt_sel7 got %0d want 0", perf_cnt);
        end
        perf_sel = 3'd2;
        perf_clr = 1'b1;
        stall_req = 5'b00100;
        tick();
        perf_clr = 1'b0;
        stall_req = 5'b00000;
        #1;
        nVectors++;
        if (perf_cnt !== 32'd0) begin
            nMiscompares++;
            $display("[TB] FAIL cnt_clr_wins got %0d want 0", perf_cnt);
        end
    endtask

    task automatic test_reset_mid_pend();
        stall_req = 5'b10000;
        excp_valid = 1'b1;
        excp_target = 32'h0000DEAD;
        tick();
        excp_valid = 1'b0;
        #1;
        nVectors++;
        if (busy_flush !== 1'b1 || flush !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL rpend_pending got busy=%b flush=%b want 1 0", busy_flush, flush);
        end
        rst = 1'b1;
        #1;
        nVectors++;
        if (stall !== 6'b000000) begin
            nMiscompares++;
            $display("[TB] FAIL rpend_stall_in_rst got %b want 000000", stall);
        end
        tick();
        rst = 1'b0;
        stall_req = 5'b00000;
        perf_sel = 3'd4;
        #1;
        nVectors++;
        if (busy_flush !== 1'b0 || stall_timeout !== 1'b0 || perf_cnt !== 32'd0) begin
            nMiscompares++;
            $display("[TB] FAIL rpend_after got busy=%b to=%b cnt=%0d want 0 0 0", busy_flush, stall_timeout, perf_cnt);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            nVectors++;
            if (flush !== 1'b0 || busy_flush !== 1'b0 || new_pc !== 32'h0) begin
                nMiscompares++;
                $display("[TB] FAIL rpend_noflush c%0d got flush=%b busy=%b pc=%h want 0 0 0", c, flush, busy_flush, new_pc);
            end
        end
    endtask

    initial begin
        nVectors = 0;
        nMiscompares = 0;
        rst = 1'b1;
        stall_req = '0;
        excp_valid = 1'b0;
        excp_target = '0;
        perf_sel = '0;
        perf_clr = 1'b0;
        test_reset();
        test_merge();
        test_immediate_flush();
        test_deferred_flush();
        test_watchdog();
        test_counters();
        test_reset_mid_pend();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
